// File: rtl/unit_result_sink_if.sv
// Bundle between the arithmetic unit, its operand issuer and the downstream consumer.
// With UNIT_RESULT_SINK_STATS_EN defined, the bundle also carries stat_rx and stat_tx.
interface unit_result_sink_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                      issue_in;
  logic                      can_issue;
  logic                      res_valid;
  logic signed [2*WIDTH-1:0] res_data;
  logic                      m_valid;
  logic                      m_ready;
  logic signed [2*WIDTH-1:0] m_data;
  logic [CW-1:0]             fill;
  logic [CW-1:0]             inflight;
  logic                      overflow;
  logic                      err_issue;
  logic                      err_unexpected;
`ifdef UNIT_RESULT_SINK_STATS_EN
  logic [31:0]               stat_rx;
  logic [31:0]               stat_tx;

  modport master (
    output issue_in, res_valid, res_data, m_ready,
    input  can_issue, m_valid, m_data, fill, inflight,
    input  overflow, err_issue, err_unexpected, stat_rx, stat_tx
  );
  modport slave (
    input  issue_in, res_valid, res_data, m_ready,
    output can_issue, m_valid, m_data, fill, inflight,
    output overflow, err_issue, err_unexpected, stat_rx, stat_tx
  );
`else
  modport master (
    output issue_in, res_valid, res_data, m_ready,
    input  can_issue, m_valid, m_data, fill, inflight,
    input  overflow, err_issue, err_unexpected
  );
  modport slave (
    input  issue_in, res_valid, res_data, m_ready,
    output can_issue, m_valid, m_data, fill, inflight,
    output overflow, err_issue, err_unexpected
  );
`endif
endinterface

// File: rtl/unit_result_sink.sv
// Result sink for the arithmetic unit: credit tracking, capture FIFO and a valid/ready output stream.
// Optional capture/pop counters are enabled by defining UNIT_RESULT_SINK_STATS_EN.
module unit_result_sink #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int DATA_LAG = 1
) (
  input  logic              clk,
  input  logic              rst,
  unit_result_sink_if.slave sink
);
  localparam int DW = 2 * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        fill_q, fill_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic                 wr_pend_q, wr_pend_d;
  logic                 overflow_q, overflow_d;
  logic                 err_issue_q, err_issue_d;
  logic                 err_unexpected_q, err_unexpected_d;
  logic signed [DW-1:0] mem_q [DEPTH];

  logic                 capture;
  logic                 pop;
  logic                 push_ok;
  logic                 full;
  logic                 can_issue;
  logic                 m_valid;
  logic [SW-1:0]        credit_sum;

  always_comb begin
    // Everything already committed to the FIFO counts against the credit budget.
    credit_sum = {1'b0, fill_q} + {1'b0, inflight_q} + SW'(wr_pend_q);
    can_issue  = credit_sum < {1'b0, DEPTH_C};

    capture   = (DATA_LAG == 0) ? sink.res_valid : wr_pend_q;
    wr_pend_d = (DATA_LAG == 0) ? 1'b0 : sink.res_valid;
    m_valid   = (fill_q != '0);
    full      = (fill_q == DEPTH_C);
    pop       = m_valid && sink.m_ready;
    // A pop in the same cycle frees the slot the capture needs.
    push_ok   = capture && (!full || pop);

    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    fill_d   = fill_q + CW'(push_ok) - CW'(pop);

    inflight_d = inflight_q;
    if (sink.issue_in && !sink.res_valid && inflight_q != DEPTH_C)
      inflight_d = inflight_q + CW'(1);
    else if (!sink.issue_in && sink.res_valid && inflight_q != '0)
      inflight_d = inflight_q - CW'(1);

    overflow_d       = overflow_q | (capture && !push_ok);
    err_issue_d      = err_issue_q | (sink.issue_in && !can_issue);
    err_unexpected_d = err_unexpected_q |
                       (sink.res_valid && !sink.issue_in && inflight_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      fill_q           <= '0;
      inflight_q       <= '0;
      wr_pend_q        <= 1'b0;
      overflow_q       <= 1'b0;
      err_issue_q      <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      fill_q           <= fill_d;
      inflight_q       <= inflight_d;
      wr_pend_q        <= wr_pend_d;
      overflow_q       <= overflow_d;
      err_issue_q      <= err_issue_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  // Storage carries no reset; fill==0 already masks stale entries.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= sink.res_data;
  end

`ifdef UNIT_RESULT_SINK_STATS_EN
  logic [31:0] stat_rx_q, stat_rx_d;
  logic [31:0] stat_tx_q, stat_tx_d;

  always_comb begin
    stat_rx_d = stat_rx_q + 32'(capture);
    stat_tx_d = stat_tx_q + 32'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rx_q <= '0;
      stat_tx_q <= '0;
    end else begin
      stat_rx_q <= stat_rx_d;
      stat_tx_q <= stat_tx_d;
    end
  end

  assign sink.stat_rx = stat_rx_q;
  assign sink.stat_tx = stat_tx_q;
`endif

  assign sink.can_issue      = can_issue;
  assign sink.m_valid        = m_valid;
  assign sink.m_data         = m_valid ? mem_q[rd_ptr_q] : '0;
  assign sink.fill           = fill_q;
  assign sink.inflight       = inflight_q;
  assign sink.overflow       = overflow_q;
  assign sink.err_issue      = err_issue_q;
  assign sink.err_unexpected = err_unexpected_q;
endmodule
